// File: rtl/spu_sm_pkg.sv
// Shared constants and state encoding for the softmax max/subtract pre-stage.
// Optional per-lane masking is enabled by defining SPU_SM_MAXSUB_MASK_EN.
package spu_sm_pkg;

    localparam int LANES = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int OW    = DW + 1;

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        MAX  = 3'b101,
        SUB  = 3'b110
    } state_t;

    // Most negative int8; identity element for the running max.
    localparam logic [DW-1:0] DATA_MIN  = 8'h80;
    // Output for masked lanes; the exponent stage maps it to zero.
    localparam logic [OW-1:0] MASK_FILL = 9'h100;

endpackage

// File: rtl/spu_sm_lane_max.sv
// Combinational signed max over the lanes of one beat.
// Masked lanes are replaced by the most negative value so they never win.
module spu_sm_lane_max
    import spu_sm_pkg::*;
(
    input  logic [LANES*DW-1:0] i_lanes,
    input  logic [LANES-1:0]    i_mask,
    output logic [DW-1:0]       o_max
);

    logic signed [DW-1:0] w_v [LANES];

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_v[i] = i_mask[i] ? $signed(DATA_MIN) : $signed(i_lanes[i*DW +: DW]);
        end
        // Pairwise reduction: after the pass with stride s, w_v[i] holds the max of 2*s lanes.
        for (int s = 1; s < LANES; s = s * 2) begin
            for (int i = 0; i + s < LANES; i = i + 2 * s) begin
                if (w_v[i+s] > w_v[i]) begin
                    w_v[i] = w_v[i+s];
                end
            end
        end
        o_max = w_v[0];
    end

endmodule

// File: rtl/spu_sm_max_sub.sv
// Softmax pre-stage: buffers one row while tracking its max, then replays x - max.
// Optional lane masking is enabled by defining SPU_SM_MAXSUB_MASK_EN.
module spu_sm_max_sub
    import spu_sm_pkg::*;
(
    input  logic                core_clk,
    input  logic                rst,
    input  logic                start,
    input  logic [AW:0]         row_len,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*DW-1:0] in_data,
`ifdef SPU_SM_MAXSUB_MASK_EN
    input  logic [LANES-1:0]    in_mask,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*OW-1:0] out_data,
    output logic                out_last,
    output logic [DW-1:0]       row_max,
    output logic                busy,
    output logic                done,
    output logic [2:0]          dbg_state
);

    // Handshakes: a beat moves on a clock edge where valid && ready are both high.
    // A producer never drops valid or changes its data before that edge.

    localparam logic [AW:0] ONE = (AW+1)'(1);

    state_t                r_state;
    state_t                w_next;
    logic [AW:0]           r_len;
    logic [AW:0]           r_wr_cnt;
    logic [AW:0]           r_rd_cnt;
    logic [DW-1:0]         r_max;
    logic [LANES*DW-1:0]   r_buf [DEPTH];
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [LANES*OW-1:0]   r_out_data;

    logic                  w_start_ok;
    logic                  w_in_hs;
    logic                  w_last_in;
    logic                  w_out_hs;
    logic                  w_load;
    logic [DW-1:0]         w_beat_max;
    logic [LANES-1:0]      w_in_mask;
    logic [LANES-1:0]      w_rd_mask;
    logic [LANES*DW-1:0]   w_rd_data;
    logic [LANES*OW-1:0]   w_diff;

    assign w_start_ok = start && (row_len != '0) && (row_len <= (AW+1)'(DEPTH));
    assign w_in_hs    = (r_state == MAX) && in_valid;
    assign w_last_in  = w_in_hs && (r_wr_cnt == r_len - ONE);
    assign w_out_hs   = r_out_valid && out_ready;
    assign w_load     = (r_state == SUB) && (!r_out_valid || out_ready) && (r_rd_cnt < r_len);
    assign w_rd_data  = r_buf[r_rd_cnt[AW-1:0]];

`ifdef SPU_SM_MAXSUB_MASK_EN
    logic [LANES-1:0] r_mask_buf [DEPTH];

    assign w_in_mask = in_mask;
    assign w_rd_mask = r_mask_buf[r_rd_cnt[AW-1:0]];

    always_ff @(posedge core_clk) begin
        if (w_in_hs) begin
            r_mask_buf[r_wr_cnt[AW-1:0]] <= in_mask;
        end
    end
`else
    assign w_in_mask = '0;
    assign w_rd_mask = '0;
`endif

    spu_sm_lane_max u_lane_max (
        .i_lanes (in_data),
        .i_mask  (w_in_mask),
        .o_max   (w_beat_max)
    );

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_start_ok) w_next = MAX;
            end
            MAX: begin
                in_ready = 1'b1;
                if (w_last_in) w_next = SUB;
            end
            SUB: begin
                done = w_out_hs && r_out_last;
                if (done) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Both operands are sign-extended to 9 bits; x - max lies in -255..0 so it cannot wrap.
    always_comb begin
        logic [DW-1:0] lane_v;
        w_diff = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_v = w_rd_data[i*DW +: DW];
            w_diff[i*OW +: OW] = {lane_v[DW-1], lane_v} - {r_max[DW-1], r_max};
            if (w_rd_mask[i]) begin
                w_diff[i*OW +: OW] = MASK_FILL;
            end
        end
    end

    always_ff @(posedge core_clk) begin
        if (w_in_hs) begin
            r_buf[r_wr_cnt[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            r_len       <= '0;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_max       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_len    <= row_len;
                        r_wr_cnt <= '0;
                        r_max    <= DATA_MIN;
                    end
                end
                MAX: begin
                    if (w_in_hs) begin
                        r_wr_cnt <= r_wr_cnt + ONE;
                        if ($signed(w_beat_max) > $signed(r_max)) begin
                            r_max <= w_beat_max;
                        end
                        if (w_last_in) begin
                            r_rd_cnt <= '0;
                        end
                    end
                end
                SUB: begin
                    if (w_load) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_diff;
                        r_out_last  <= (r_rd_cnt == r_len - ONE);
                        r_rd_cnt    <= r_rd_cnt + ONE;
                    end else if (w_out_hs) begin
                        // Only reachable once the final beat has been taken.
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign row_max   = r_max;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_spu_sm_max_sub.sv
// Self-checking bench for spu_sm_max_sub against a row-level softmax pre-stage model.
// Mask scenarios are compiled in when SPU_SM_MAXSUB_MASK_EN is defined.
module tb_spu_sm_max_sub;
    import spu_sm_pkg::*;

    logic                core_clk = 1'b0;
    logic                rst;
    logic                start;
    logic [AW:0]         row_len;
    logic                in_valid;
    logic                in_ready;
    logic [LANES*DW-1:0] in_data;
`ifdef SPU_SM_MAXSUB_MASK_EN
    logic [LANES-1:0]    in_mask;
`endif
    logic                out_valid;
    logic                out_ready;
    logic [LANES*OW-1:0] out_data;
    logic                out_last;
    logic [DW-1:0]       row_max;
    logic                busy;
    logic                done;
    logic [2:0]          dbg_state;

    spu_sm_max_sub dut (
        .core_clk  (core_clk),
        .rst       (rst),
        .start     (start),
        .row_len   (row_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef SPU_SM_MAXSUB_MASK_EN
        .in_mask   (in_mask),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .row_max   (row_max),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 core_clk = ~core_clk;

    int cyc = 0;
    always @(posedge core_clk) cyc <= cyc + 1;

    // ---------------- scoreboard / model state ----------------
    int                  n_checks;
    int                  n_pass;
    int                  row_data [DEPTH][LANES];
    bit                  row_mask [DEPTH][LANES];
    logic [LANES*OW-1:0] exp_q[$];
    logic [LANES*OW-1:0] got_q[$];
    logic                got_last_q[$];
    int                  exp_max;
    int                  hs_cyc;
    int                  first_valid_cyc;
    int                  stall_viol;
    int                  done_cnt;
    bit                  timeout;
    bit                  feed_ok;

    // Reference: row max over unmasked lanes (floor -128), then x - max or -256 per lane.
    task automatic build_expected(input int len);
        int m;
        logic [LANES*OW-1:0] v;
        m = -128;
        for (int b = 0; b < len; b++)
            for (int i = 0; i < LANES; i++)
                if (!row_mask[b][i] && row_data[b][i] > m) m = row_data[b][i];
        exp_max = m;
        exp_q.delete();
        for (int b = 0; b < len; b++) begin
            for (int i = 0; i < LANES; i++)
                v[i*OW +: OW] = row_mask[b][i] ? 9'h100 : 9'(row_data[b][i] - m);
            exp_q.push_back(v);
        end
    endtask

    task automatic fill_random(input int len, input int mask_pct);
        for (int b = 0; b < len; b++)
            for (int i = 0; i < LANES; i++) begin
                row_data[b][i] = int'($urandom_range(0, 255)) - 128;
`ifdef SPU_SM_MAXSUB_MASK_EN
                row_mask[b][i] = ($urandom_range(0, 99) < mask_pct);
`else
                row_mask[b][i] = (mask_pct < 0);
`endif
            end
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_row(input int len);
        start   = 1'b1;
        row_len = (AW+1)'(len);
        @(posedge core_clk); #1;
        start   = 1'b0;
        row_len = '0;
    endtask

    task automatic feed_row(input int n, input int gap_pct);
        int b;
        int guard;
        bit hs;
        b = 0;
        guard = 0;
        while (b < n && guard < 20000) begin
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            for (int i = 0; i < LANES; i++) begin
                in_data[i*DW +: DW] = 8'(row_data[b][i]);
`ifdef SPU_SM_MAXSUB_MASK_EN
                in_mask[i] = row_mask[b][i];
`endif
            end
            hs = in_valid && in_ready;
            if (hs) hs_cyc = cyc;
            @(posedge core_clk); #1;
            if (hs) b++;
            guard++;
        end
        in_valid = 1'b0;
        feed_ok  = (b == n);
    endtask

    task automatic drain(input int ready_pct, input int stall_first, input bit toggle);
        int guard;
        bit fin;
        bit have_prev;
        logic [LANES*OW-1:0] prev_data;
        logic prev_last;
        got_q.delete();
        got_last_q.delete();
        first_valid_cyc = -1;
        stall_viol = 0;
        done_cnt = 0;
        timeout = 0;
        guard = 0;
        fin = 0;
        have_prev = 0;
        prev_data = '0;
        prev_last = 0;
        while (!fin) begin
            if (guard >= 20000) begin
                timeout = 1;
                break;
            end
            if (guard < stall_first) out_ready = 1'b0;
            else if (toggle)         out_ready = guard[0];
            else                     out_ready = ($urandom_range(0, 99) < ready_pct);
            #1;
            if (have_prev && (!out_valid || out_data !== prev_data || out_last !== prev_last))
                stall_viol++;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                got_last_q.push_back(out_last);
                if (out_last) fin = 1;
            end
            have_prev = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            @(posedge core_clk); #1;
            guard++;
        end
        out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge core_clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL reset_out_data: got %h expected 0", out_data); else n_pass++;
        n_checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b expected 0", out_last); else n_pass++;
        n_checks++; if (row_max !== 8'h00) $display("FAIL reset_row_max: got %h expected 00", row_max); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        n_checks++; if (dbg_state !== 3'b000) $display("FAIL reset_state: got %b expected 000", dbg_state); else n_pass++;
        rst = 1'b0;
        @(posedge core_clk); #1;
    endtask

    task automatic test_len1();
        int lanes_in [LANES] = '{-3, 5, 0, 127, -128, 1, 2, 3};
        int lanes_out [LANES] = '{-130, -122, -127, 0, -255, -126, -125, -124};
        logic [LANES*OW-1:0] g;
        for (int i = 0; i < LANES; i++) begin
            row_data[0][i] = lanes_in[i];
            row_mask[0][i] = 0;
        end
        build_expected(1);
        start_row(1);
        feed_row(1, 0);
        drain(100, 0, 0);
        n_checks++; if (timeout || !feed_ok) $display("FAIL len1_timeout: got timeout=%0d feed_ok=%0d expected 0/1", timeout, feed_ok); else n_pass++;
        n_checks++; if (row_max !== 8'd127) $display("FAIL len1_row_max: got %0d expected 127", $signed(row_max)); else n_pass++;
        n_checks++; if (got_q.size() != 1) $display("FAIL len1_beats: got %0d expected 1", got_q.size()); else n_pass++;
        if (got_q.size() == 1) begin
            g = got_q[0];
            for (int i = 0; i < LANES; i++) begin
                n_checks++;
                if ($signed(g[i*OW +: OW]) != lanes_out[i])
                    $display("FAIL len1_lane%0d: got %0d expected %0d", i, $signed(g[i*OW +: OW]), lanes_out[i]);
                else n_pass++;
            end
            n_checks++; if (g !== exp_q[0]) $display("FAIL len1_model: got %h expected %h", g, exp_q[0]); else n_pass++;
            n_checks++; if (got_last_q[0] !== 1'b1) $display("FAIL len1_last: got %b expected 1", got_last_q[0]); else n_pass++;
        end
        n_checks++; if (done_cnt != 1) $display("FAIL len1_done: got %0d pulses expected 1", done_cnt); else n_pass++;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL len1_idle: got busy=%b done=%b expected 0/0", busy, done); else n_pass++;
    endtask

    task automatic test_max_last();
        logic [LANES*OW-1:0] g;
        int hot;
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < LANES; i++) begin
                row_data[b][i] = int'($urandom_range(0, 167)) - 128;
                row_mask[b][i] = 0;
            end
        hot = int'($urandom_range(0, LANES - 1));
        row_data[3][hot] = 40;
        build_expected(4);
        start_row(4);
        feed_row(4, 30);
        n_checks++; if (row_max !== 8'd40) $display("FAIL maxlast_row_max: got %0d expected 40", $signed(row_max)); else n_pass++;
        drain(100, 0, 0);
        n_checks++; if (timeout || !feed_ok) $display("FAIL maxlast_timeout: got timeout=%0d feed_ok=%0d expected 0/1", timeout, feed_ok); else n_pass++;
        n_checks++; if (first_valid_cyc - hs_cyc != 2) $display("FAIL maxlast_latency: got %0d expected 2", first_valid_cyc - hs_cyc); else n_pass++;
        n_checks++; if (got_q.size() != 4) $display("FAIL maxlast_beats: got %0d expected 4", got_q.size()); else n_pass++;
        for (int b = 0; b < got_q.size() && b < 4; b++) begin
            n_checks++;
            if (got_q[b] !== exp_q[b] || got_last_q[b] !== (b == 3))
                $display("FAIL maxlast_beat%0d: got %h/%b expected %h/%b", b, got_q[b], got_last_q[b], exp_q[b], (b == 3));
            else n_pass++;
        end
        if (got_q.size() == 4) begin
            g = got_q[3];
            n_checks++; if (g[hot*OW +: OW] !== 9'd0) $display("FAIL maxlast_zero: got %h expected 000", g[hot*OW +: OW]); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        fill_random(3, 0);
        build_expected(3);
        start_row(3);
        feed_row(3, 0);
        drain(0, 5, 1);
        n_checks++; if (timeout) $display("FAIL bp_timeout: got timeout expected completion"); else n_pass++;
        n_checks++; if (stall_viol != 0) $display("FAIL bp_stable: got %0d changes while stalled expected 0", stall_viol); else n_pass++;
        n_checks++; if (got_q.size() != 3) $display("FAIL bp_beats: got %0d expected 3", got_q.size()); else n_pass++;
        for (int b = 0; b < got_q.size() && b < 3; b++) begin
            n_checks++;
            if (got_q[b] !== exp_q[b]) $display("FAIL bp_beat%0d: got %h expected %h", b, got_q[b], exp_q[b]);
            else n_pass++;
        end
        n_checks++; if (done_cnt != 1) $display("FAIL bp_done: got %0d pulses expected 1", done_cnt); else n_pass++;
    endtask

    task automatic test_ignored_start();
        fill_random(3, 0);
        build_expected(3);
        start_row(3);
        feed_row(3, 0);
        start_row(2);
        n_checks++; if (busy !== 1'b1 || dbg_state !== 3'b110) $display("FAIL ign_sub_state: got busy=%b state=%b expected 1/110", busy, dbg_state); else n_pass++;
        drain(70, 0, 0);
        n_checks++; if (timeout || got_q.size() != 3) $display("FAIL ign_sub_beats: got %0d beats expected 3", got_q.size()); else n_pass++;
        for (int b = 0; b < got_q.size() && b < 3; b++) begin
            n_checks++;
            if (got_q[b] !== exp_q[b]) $display("FAIL ign_sub_beat%0d: got %h expected %h", b, got_q[b], exp_q[b]);
            else n_pass++;
        end
        start_row(0);
        n_checks++; if (busy !== 1'b0 || dbg_state !== 3'b000) $display("FAIL ign_len0: got busy=%b state=%b expected 0/000", busy, dbg_state); else n_pass++;
        start_row(DEPTH + 1);
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL ign_len65: got busy=%b in_ready=%b expected 0/0", busy, in_ready); else n_pass++;
        n_checks++; if ($signed(row_max) != exp_max) $display("FAIL ign_row_max_hold: got %0d expected %0d", $signed(row_max), exp_max); else n_pass++;
    endtask

    task automatic test_rst_mid();
        fill_random(4, 0);
        start_row(4);
        feed_row(2, 0);
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || dbg_state !== 3'b000 || in_ready !== 1'b0) $display("FAIL rst_mid_state: got busy=%b state=%b in_ready=%b expected 0/000/0", busy, dbg_state, in_ready); else n_pass++;
        n_checks++; if (row_max !== 8'h00 || out_valid !== 1'b0) $display("FAIL rst_mid_outputs: got row_max=%h out_valid=%b expected 00/0", row_max, out_valid); else n_pass++;
        @(posedge core_clk); #1;
        rst = 1'b0;
        @(posedge core_clk); #1;
        fill_random(2, 0);
        build_expected(2);
        start_row(2);
        feed_row(2, 20);
        drain(60, 0, 0);
        n_checks++; if (timeout || !feed_ok || got_q.size() != 2) $display("FAIL rst_fresh_beats: got %0d expected 2", got_q.size()); else n_pass++;
        for (int b = 0; b < got_q.size() && b < 2; b++) begin
            n_checks++;
            if (got_q[b] !== exp_q[b]) $display("FAIL rst_fresh_beat%0d: got %h expected %h", b, got_q[b], exp_q[b]);
            else n_pass++;
        end
        n_checks++; if ($signed(row_max) != exp_max) $display("FAIL rst_fresh_max: got %0d expected %0d", $signed(row_max), exp_max); else n_pass++;
    endtask

    // Back-to-back random rows, including the DEPTH and single-beat boundaries.
    task automatic test_random();
        int len;
        int errs;
        for (int r = 0; r < 8; r++) begin
            len = (r == 0) ? DEPTH : (r == 1) ? 1 : int'($urandom_range(1, DEPTH));
            fill_random(len, 20);
            build_expected(len);
            start_row(len);
            feed_row(len, int'($urandom_range(0, 60)));
            n_checks++; if ($signed(row_max) != exp_max) $display("FAIL rand%0d_row_max: got %0d expected %0d", r, $signed(row_max), exp_max); else n_pass++;
            drain(int'($urandom_range(30, 100)), 0, 0);
            n_checks++; if (timeout || !feed_ok || got_q.size() != len) $display("FAIL rand%0d_beats: got %0d expected %0d", r, got_q.size(), len); else n_pass++;
            errs = 0;
            for (int b = 0; b < got_q.size() && b < len; b++)
                if (got_q[b] !== exp_q[b] || got_last_q[b] !== (b == len - 1)) begin
                    if (errs == 0) $display("FAIL rand%0d_beat%0d: got %h/%b expected %h/%b", r, b, got_q[b], got_last_q[b], exp_q[b], (b == len - 1));
                    errs++;
                end
            n_checks++; if (errs != 0) $display("FAIL rand%0d_data: got %0d bad beats expected 0", r, errs); else n_pass++;
            n_checks++; if (stall_viol != 0 || done_cnt != 1) $display("FAIL rand%0d_hs: got stall_viol=%0d done=%0d expected 0/1", r, stall_viol, done_cnt); else n_pass++;
        end
    endtask

`ifdef SPU_SM_MAXSUB_MASK_EN
    task automatic test_mask();
        logic [LANES*OW-1:0] g;
        int errs;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < LANES; i++) begin
                row_data[b][i] = int'($urandom_range(0, 138)) - 128;
                row_mask[b][i] = (i == 3);
            end
        row_data[0][3] = 127;
        row_data[1][3] = 127;
        row_data[1][6] = 10;
        build_expected(2);
        start_row(2);
        feed_row(2, 0);
        drain(100, 0, 0);
        n_checks++; if (row_max !== 8'd10) $display("FAIL mask_row_max: got %0d expected 10", $signed(row_max)); else n_pass++;
        n_checks++; if (timeout || got_q.size() != 2) $display("FAIL mask_beats: got %0d expected 2", got_q.size()); else n_pass++;
        for (int b = 0; b < got_q.size() && b < 2; b++) begin
            g = got_q[b];
            n_checks++; if (g[3*OW +: OW] !== 9'h100) $display("FAIL mask_lane3_b%0d: got %h expected 100", b, g[3*OW +: OW]); else n_pass++;
            n_checks++; if (g !== exp_q[b]) $display("FAIL mask_beat%0d: got %h expected %h", b, g, exp_q[b]); else n_pass++;
        end
        fill_random(3, 100);
        build_expected(3);
        start_row(3);
        feed_row(3, 0);
        drain(100, 0, 0);
        n_checks++; if (row_max !== 8'h80) $display("FAIL mask_all_max: got %0d expected -128", $signed(row_max)); else n_pass++;
        errs = 0;
        for (int b = 0; b < got_q.size(); b++) begin
            g = got_q[b];
            for (int i = 0; i < LANES; i++) if (g[i*OW +: OW] !== 9'h100) errs++;
        end
        n_checks++; if (timeout || got_q.size() != 3 || errs != 0) $display("FAIL mask_all_out: got %0d beats %0d bad lanes expected 3/0", got_q.size(), errs); else n_pass++;
    endtask
`endif

    // ---------------- main sequence / report ----------------
    initial begin
        rst = 1'b1;
        start = 1'b0;
        row_len = '0;
        in_valid = 1'b0;
        in_data = '0;
`ifdef SPU_SM_MAXSUB_MASK_EN
        in_mask = '0;
`endif
        out_ready = 1'b0;
        n_checks = 0;
        n_pass = 0;
        test_reset();
        test_len1();
        test_max_last();
        test_backpressure();
        test_ignored_start();
        test_rst_mid();
        test_random();
`ifdef SPU_SM_MAXSUB_MASK_EN
        test_mask();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
